// File: rtl/mealy_cond_pkg.sv
// mealy_cond_pkg: shared types and constants for the Mealy input conditioner.
// Debounce FSM state encoding plus simulation / silicon debounce lengths.
package mealy_cond_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESS   = 2'd1,
    HELD    = 2'd2,
    RELEASE = 2'd3
  } cond_state_t;

  localparam int DEBOUNCE_SIM = 16;
  localparam int DEBOUNCE_SI  = 100000;

endpackage

// File: rtl/mealy_input_conditioner_sync_2ff.sv
// sync_2ff: 1-bit two-flop synchroniser for asynchronous pad inputs.
// Async active-low reset clears both stages to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/mealy_input_conditioner.sv
// mealy_input_conditioner: sync + debounce step button, emit one bit strobe per press.
// Optional 8-bit accepted-bit history under MEALY_COND_HISTORY_EN.
module mealy_input_conditioner
  import mealy_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_SIM,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       din_raw,
  input  logic       step_raw,
  output logic       bit_out,
  output logic       bit_valid,
  output logic [1:0] state_dbg,
  output logic [7:0] hist
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic s_din;
  logic s_step;

  sync_2ff u_sync_din (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (din_raw),
    .q     (s_din)
  );

  sync_2ff u_sync_step (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (step_raw),
    .q     (s_step)
  );

  cond_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bit_out_q, bit_out_d;
  logic             bit_valid_q, bit_valid_d;
  logic             take;
  logic             cnt_last;

  assign cnt_last = (cnt_q == CNT_LAST);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_out_d   = bit_out_q;
    bit_valid_d = 1'b0;
    take        = 1'b0;
    if (!ena) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (s_step) begin
            state_d = PRESS;
            cnt_d   = '0;
          end
        end
        PRESS: begin
          if (!s_step) begin
            state_d = IDLE;
          end else if (cnt_last) begin
            state_d = HELD;
            take    = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        HELD: begin
          if (!s_step) begin
            state_d = RELEASE;
            cnt_d   = '0;
          end
        end
        RELEASE: begin
          // a high sample here is contact bounce, not a new press
          if (s_step) begin
            state_d = HELD;
          end else if (cnt_last) begin
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
    if (take) begin
      bit_out_d   = s_din;
      bit_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_out_q   <= 1'b0;
      bit_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_out_q   <= bit_out_d;
      bit_valid_q <= bit_valid_d;
    end
  end

  assign bit_out   = bit_out_q;
  assign bit_valid = bit_valid_q;
  assign state_dbg = state_q;

`ifdef MEALY_COND_HISTORY_EN
  logic [7:0] hist_q, hist_d;

  always_comb begin
    hist_d = hist_q;
    if (take) begin
      hist_d = {hist_q[6:0], s_din};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q <= 8'h00;
    end else begin
      hist_q <= hist_d;
    end
  end

  assign hist = hist_q;
`else
  assign hist = 8'h00;
`endif

endmodule
